// File: rtl/mult4_pkg.sv
// rtl/mult4_pkg.sv - shared state encoding and widths for the 4x4 multiplier sequencer
package mult4_pkg;

  localparam int OPW         = 4;
  localparam int PW          = 8;
  localparam int MUL_LATENCY = 6;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LAUNCH = 3'd1,
    ST_GUARD  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_HOLD   = 3'd4
  } state_e;

endpackage

// File: rtl/mult4_wait_timer.sv
// rtl/mult4_wait_timer.sv - saturating cycle counter that flags the last allowed WAIT cycle
module mult4_wait_timer (
  input  logic       ck_i,
  input  logic       rn_i,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic [3:0] wait_max_i,
  output logic       expired_o
);

  logic [3:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (enable_i && (cnt_q != 4'hF)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  always_ff @(posedge ck_i or negedge rn_i) begin
    if (!rn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // cnt_q holds completed WAIT cycles, so the current cycle number is cnt_q + 1
  assign expired_o = enable_i && (({1'b0, cnt_q} + 5'd1) >= {1'b0, wait_max_i});

endmodule

// File: rtl/mult4_seq_ctrl.sv
// rtl/mult4_seq_ctrl.sv - operand sequencer and result/accumulator collector around the shift-add core
module mult4_seq_ctrl
  import mult4_pkg::*;
#(
  parameter int ACC_W    = 12,
  parameter int WAIT_MAX = 15
) (
  input  logic             ck_i,
  input  logic             rn_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [OPW-1:0]   in_a_i,
  input  logic [OPW-1:0]   in_b_i,
  input  logic             acc_clr_i,
  output logic [OPW-1:0]   mul_a_o,
  output logic [OPW-1:0]   mul_b_o,
  output logic             mul_start_o,
  input  logic             mul_ready_i,
  input  logic [PW-1:0]    mul_p_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [PW-1:0]    out_p_o,
  output logic [ACC_W-1:0] out_acc_o,
  output logic             busy_o,
  output logic             timeout_o
);

  state_e           state_q, state_d;
  logic [OPW-1:0]   mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [PW-1:0]    out_p_q, out_p_d;
  logic [ACC_W-1:0] acc_q, acc_d, acc_base;
  logic             timeout_q, timeout_d;
  logic             expired, capture, time_out;

  mult4_wait_timer u_timer (
    .ck_i       (ck_i),
    .rn_i       (rn_i),
    .clear_i    (state_q != ST_WAIT),
    .enable_i   (state_q == ST_WAIT),
    .wait_max_i (4'(WAIT_MAX)),
    .expired_o  (expired)
  );

  always_comb begin
    state_d  = state_q;
    mul_a_d  = mul_a_q;
    mul_b_d  = mul_b_q;
    out_p_d  = out_p_q;
    capture  = 1'b0;
    time_out = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid_i) begin
          mul_a_d = in_a_i;
          mul_b_d = in_b_i;
          state_d = ST_LAUNCH;
        end
      end
      ST_LAUNCH: state_d = ST_GUARD;
      // READY may still be high from the previous job here, so it is not sampled
      ST_GUARD:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (mul_ready_i) begin
          capture = 1'b1;
          out_p_d = mul_p_i;
          state_d = ST_HOLD;
        end else if (expired) begin
          time_out = 1'b1;
          out_p_d  = '0;
          state_d  = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // a clear coinciding with a capture restarts the sum at this product
    acc_base  = acc_clr_i ? '0 : acc_q;
    acc_d     = capture ? (acc_base + ACC_W'(mul_p_i)) : acc_base;
    timeout_d = (timeout_q & ~acc_clr_i) | time_out;
  end

  always_ff @(posedge ck_i or negedge rn_i) begin
    if (!rn_i) begin
      state_q   <= ST_IDLE;
      mul_a_q   <= '0;
      mul_b_q   <= '0;
      out_p_q   <= '0;
      acc_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mul_a_q   <= mul_a_d;
      mul_b_q   <= mul_b_d;
      out_p_q   <= out_p_d;
      acc_q     <= acc_d;
      timeout_q <= timeout_d;
    end
  end

  assign in_ready_o  = (state_q == ST_IDLE);
  assign mul_start_o = (state_q == ST_LAUNCH);
  assign out_valid_o = (state_q == ST_HOLD);
  assign busy_o      = (state_q != ST_IDLE);
  assign mul_a_o     = mul_a_q;
  assign mul_b_o     = mul_b_q;
  assign out_p_o     = out_p_q;
  assign out_acc_o   = acc_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_mult4_seq_ctrl.sv
// tb/tb_mult4_seq_ctrl.sv - directed scoreboard bench for mult4_seq_ctrl with a shift-add core model
module tb_mult4_seq_ctrl;

  logic       ck = 1'b0;
  logic       rn = 1'b0;
  logic       in_valid = 1'b0;
  logic [3:0] in_a = '0, in_b = '0;
  logic       acc_clr = 1'b0;
  logic       out_ready = 1'b1;
  logic       mul_ready;
  logic [7:0] mul_p;

  logic       in_ready, mul_start, out_valid, busy, timeout;
  logic [3:0] mul_a, mul_b;
  logic [7:0] out_p;
  logic [11:0] out_acc;

  logic       in_ready8, mul_start8, out_valid8, busy8, timeout8;
  logic [3:0] mul_a8, mul_b8;
  logic [7:0] out_p8;
  logic [7:0] out_acc8;

  int checks = 0;
  int errors = 0;

  // core select: 0 = latency-6 model, 1 = stuck (never ready), 2 = manual
  int         mode = 0;
  logic       man_ready = 1'b0;
  logic [7:0] man_p = '0;
  logic       mdl_ready = 1'b0;
  logic [7:0] mdl_p = '0;
  int         lat_c = -1;

  typedef struct {
    int p;
    int acc;
    int acc8;
    int to;
  } exp_t;

  exp_t sb[$];
  exp_t last_e;
  int   m_acc = 0, m_acc8 = 0, m_to = 0;

  always #5 ck = ~ck;

  assign mul_ready = (mode == 2) ? man_ready : (mode == 1) ? 1'b0  : mdl_ready;
  assign mul_p     = (mode == 2) ? man_p     : (mode == 1) ? 8'h00 : mdl_p;

  mult4_seq_ctrl #(.ACC_W(12), .WAIT_MAX(15)) dut (
    .ck_i(ck), .rn_i(rn), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_a_i(in_a), .in_b_i(in_b), .acc_clr_i(acc_clr),
    .mul_a_o(mul_a), .mul_b_o(mul_b), .mul_start_o(mul_start),
    .mul_ready_i(mul_ready), .mul_p_i(mul_p),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_p_o(out_p),
    .out_acc_o(out_acc), .busy_o(busy), .timeout_o(timeout)
  );

  mult4_seq_ctrl #(.ACC_W(8), .WAIT_MAX(15)) dut8 (
    .ck_i(ck), .rn_i(rn), .in_valid_i(in_valid), .in_ready_o(in_ready8),
    .in_a_i(in_a), .in_b_i(in_b), .acc_clr_i(acc_clr),
    .mul_a_o(mul_a8), .mul_b_o(mul_b8), .mul_start_o(mul_start8),
    .mul_ready_i(mul_ready), .mul_p_i(mul_p),
    .out_valid_o(out_valid8), .out_ready_i(out_ready), .out_p_o(out_p8),
    .out_acc_o(out_acc8), .busy_o(busy8), .timeout_o(timeout8)
  );

  // core model: READY rises 6 cycles after the START cycle and stays high until the next START
  always @(negedge ck) begin
    if (!rn) begin
      lat_c = -1;
      mdl_ready = 1'b0;
    end else if (mul_start) begin
      lat_c = 0;
      mdl_ready = 1'b0;
    end else if (lat_c >= 0) begin
      lat_c++;
      if (lat_c == 6) begin
        mdl_ready = 1'b1;
        mdl_p = 8'(mul_a) * 8'(mul_b);
        lat_c = -1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic push(input int p, input bit tmo, input bit clr);
    exp_t e;
    if (clr) begin
      m_acc = 0; m_acc8 = 0; m_to = 0;
    end
    if (tmo) begin
      m_to = 1;
      p = 0;
    end else begin
      m_acc  = (m_acc + p) % 4096;
      m_acc8 = (m_acc8 + p) % 256;
    end
    e.p = p; e.acc = m_acc; e.acc8 = m_acc8; e.to = m_to;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string tag);
    chk({tag, "_pending"}, 32'(sb.size()), 32'd1);
    if (sb.size() > 0) begin
      last_e = sb.pop_front();
      chk({tag, "_p"}, 32'(out_p), 32'(last_e.p));
      chk({tag, "_acc"}, 32'(out_acc), 32'(last_e.acc));
      chk({tag, "_acc8"}, 32'(out_acc8), 32'(last_e.acc8));
      chk({tag, "_timeout"}, 32'(timeout), 32'(last_e.to));
    end
  endtask

  task automatic acc_pulse(input string tag);
    acc_clr = 1'b1;
    @(negedge ck);
    acc_clr = 1'b0;
    m_acc = 0; m_acc8 = 0; m_to = 0;
    chk({tag, "_acc"}, 32'(out_acc), 32'(m_acc));
    chk({tag, "_acc8"}, 32'(out_acc8), 32'(m_acc8));
    chk({tag, "_timeout"}, 32'(timeout), 32'(m_to));
  endtask

  // called at a negedge with the DUT in IDLE; returns at the negedge after HOLD is left
  task automatic run_job(input logic [3:0] a, input logic [3:0] b, input bit tmo,
                         input int clr_at, input int hold, input string tag);
    int lat, starts, exp_lat;
    bit got;
    exp_lat = tmo ? 17 : 7;
    push(int'(a) * int'(b), tmo, clr_at >= 0);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = a; in_b = b;
    out_ready = (hold == 0);
    @(negedge ck);
    in_valid = 1'b0;
    lat = 0; starts = 0; got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      acc_clr = (lat == clr_at);
      if (mul_start) starts++;
      if (out_valid) got = 1'b1;
      else begin
        @(negedge ck);
        lat++;
      end
    end
    acc_clr = 1'b0;
    chk({tag, "_done"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_starts"}, 32'(starts), 32'd1);
    chk({tag, "_mul_a"}, 32'(mul_a), 32'(a));
    chk({tag, "_mul_b"}, 32'(mul_b), 32'(b));
    pop_check(tag);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      in_a = 4'($urandom);
      in_b = 4'($urandom);
      @(negedge ck);
      chk({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
      chk({tag, "_hold_p"}, 32'(out_p), 32'(last_e.p));
      chk({tag, "_hold_acc"}, 32'(out_acc), 32'(last_e.acc));
      chk({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      chk({tag, "_hold_mul_a"}, 32'(mul_a), 32'(a));
      chk({tag, "_hold_mul_b"}, 32'(mul_b), 32'(b));
    end
    out_ready = 1'b1;
    @(negedge ck);
    in_valid = 1'b0;
    chk({tag, "_drop_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge ck);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(mul_start), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_acc", 32'(out_acc), 32'd0);
    chk("rst_p", 32'(out_p), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    rn = 1'b1;
    @(negedge ck);

    run_job(4'd9, 4'd13, 1'b0, -1, 0, "single");
    chk("single_acc_const", 32'(out_acc), 32'd117);
    acc_pulse("clr1");

    run_job(4'd15, 4'd15, 1'b0, -1, 0, "b2b1");
    run_job(4'd15, 4'd15, 1'b0, -1, 0, "b2b2");
    run_job(4'd7, 4'd3, 1'b0, -1, 0, "b2b3");
    chk("b2b_acc12_const", 32'(out_acc), 32'd471);
    chk("b2b_acc8_const", 32'(out_acc8), 32'd215);

    mode = 2; man_ready = 1'b1; man_p = 8'd99;
    push(42, 1'b0, 1'b0);
    in_valid = 1'b1; in_a = 4'd6; in_b = 4'd7;
    @(negedge ck);
    in_valid = 1'b0;
    chk("stale_start", 32'(mul_start), 32'd1);
    @(negedge ck);
    chk("stale_guard_busy", 32'(busy), 32'd1);
    @(negedge ck);
    man_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("stale_wait_valid", 32'(out_valid), 32'd0);
      @(negedge ck);
    end
    man_ready = 1'b1; man_p = 8'd42;
    @(negedge ck);
    chk("stale_valid", 32'(out_valid), 32'd1);
    pop_check("stale");
    @(negedge ck);
    chk("stale_idle", 32'(in_ready), 32'd1);
    mode = 0;

    mode = 1;
    run_job(4'd1, 4'd1, 1'b1, -1, 0, "stuck");
    mode = 0;
    run_job(4'd2, 4'd3, 1'b0, -1, 0, "after_stuck");
    chk("sticky_timeout", 32'(timeout), 32'd1);
    acc_pulse("clr2");

    mode = 1;
    run_job(4'd1, 4'd1, 1'b1, 16, 0, "stuck_clr");
    mode = 0;

    run_job(4'd5, 4'd6, 1'b0, -1, 10, "bp");

    in_valid = 1'b1; in_a = 4'd3; in_b = 4'd3;
    @(negedge ck);
    in_valid = 1'b0;
    @(negedge ck);
    @(negedge ck);
    chk("rst_wait_busy", 32'(busy), 32'd1);
    #2 rn = 1'b0;
    #1;
    chk("arst_in_ready", 32'(in_ready), 32'd1);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_start", 32'(mul_start), 32'd0);
    chk("arst_valid", 32'(out_valid), 32'd0);
    chk("arst_p", 32'(out_p), 32'd0);
    chk("arst_acc", 32'(out_acc), 32'd0);
    chk("arst_acc8", 32'(out_acc8), 32'd0);
    chk("arst_mul_a", 32'(mul_a), 32'd0);
    chk("arst_mul_b", 32'(mul_b), 32'd0);
    chk("arst_timeout", 32'(timeout), 32'd0);
    m_acc = 0; m_acc8 = 0; m_to = 0;
    @(negedge ck);
    rn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge ck);
      chk("post_rst_start", 32'(mul_start), 32'd0);
      chk("post_rst_ready", 32'(in_ready), 32'd1);
    end

    run_job(4'd15, 4'd15, 1'b0, -1, 0, "pre1");
    run_job(4'd15, 4'd5, 1'b0, -1, 0, "pre2");
    chk("pre_acc_const", 32'(out_acc), 32'd300);
    run_job(4'd4, 4'd5, 1'b0, 6, 0, "clr_cap");
    chk("clr_cap_acc_const", 32'(out_acc), 32'd20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult4_seq_ctrl.md
Name: mult4_seq_ctrl

Overview:
Operand sequencer and result collector wrapped around the 4x4 shift-add multiplier core (ports START, A3..A0, B3..B0, READY, P7..P0).
- Upstream: accepts operand pairs over a valid/ready handshake.
- Core side: launches one multiply, holds operands stable, waits for READY with a timeout, then captures P.
- Downstream: presents the product plus a running accumulated sum over a valid/ready handshake.

Parameters:
ACC_W, 12, accumulator width in bits (>= 8); sum wraps modulo 2^ACC_W
WAIT_MAX, 15, maximum cycles spent in WAIT before timeout (>= 6)

Ports:
CK  in  1  clock, rising edge
RN  in  1  asynchronous active-low reset
IN_VALID  in  1  operand pair valid
IN_READY  out  1  controller can accept operands
IN_A  in  4  multiplicand
IN_B  in  4  multiplier
ACC_CLR  in  1  synchronous accumulator and TIMEOUT clear
MUL_A  out  4  to core A3..A0
MUL_B  out  4  to core B3..B0
MUL_START  out  1  to core START
MUL_READY  in  1  from core READY
MUL_P  in  8  from core P7..P0
OUT_VALID  out  1  result valid
OUT_READY  in  1  downstream accepts result
OUT_P  out  8  captured product
OUT_ACC  out  ACC_W  accumulated sum including this result
BUSY  out  1  high in any state other than IDLE
TIMEOUT  out  1  sticky timeout flag

Behaviour:
- Reset (RN low, asynchronous): state IDLE; all outputs 0 except IN_READY=1; operand, product, accumulator and timer registers cleared. Reset mid-operation abandons the multiply; MUL_START stays 0.
- States: IDLE, LAUNCH, GUARD, WAIT, HOLD.
- IDLE: IN_READY=1. When IN_VALID=1, register IN_A/IN_B into MUL_A/MUL_B and go to LAUNCH. There is no skid buffer; IN_READY=0 in all other states.
- LAUNCH: MUL_START=1 for exactly one cycle, then GUARD.
- GUARD: one cycle. MUL_READY is ignored because a stale READY from the previous job may still be high. The core counter is 0 and the core loads A. Then WAIT.
- WAIT: timer counts from 1.
  - If MUL_READY=1: capture MUL_P into OUT_P, set OUT_ACC <= OUT_ACC + zero-extended MUL_P (wraps mod 2^ACC_W), go to HOLD.
  - Nominal core: READY is seen 6 cycles after the LAUNCH cycle, so OUT_VALID rises at LAUNCH+7.
  - If the timer reaches WAIT_MAX with MUL_READY still 0: OUT_P <= 0, no accumulation, TIMEOUT <= 1, go to HOLD.
- MUL_A/MUL_B stay constant from LAUNCH through HOLD. They are only updated on acceptance in IDLE.
- HOLD: OUT_VALID=1 and OUT_P/OUT_ACC stay stable until OUT_READY=1. On OUT_READY=1, OUT_VALID drops in the next cycle and the state returns to IDLE. The minimum job period is 9 cycles.
- ACC_CLR: synchronous, any state.
  - Clears OUT_ACC and TIMEOUT.
  - If asserted in the same cycle as a capture, OUT_ACC <= zero-extended MUL_P: clear takes priority, then the add applies.
  - If asserted in the same cycle as a timeout, TIMEOUT ends at 1.
- TIMEOUT: sticky; cleared only by RN or ACC_CLR.
- OUT_ACC holds its value between jobs.

Decomposition:
- Shared package mult4_pkg:
  - state enum (IDLE=0, LAUNCH=1, GUARD=2, WAIT=3, HOLD=4, 3-bit encoding)
  - MUL_LATENCY=6
  - operand width 4, product width 8
- Sub-module mult4_wait_timer:
  - inputs: clear, enable, WAIT_MAX
  - output: expired
  - 4-bit saturating counter
- FSM, operand and result registers, and the accumulator live in the top module.

Test Plan:
- Bench drives MUL_READY and MUL_P with a core model (READY at LAUNCH+6).
- Single job: IN_A=9, IN_B=13, OUT_READY=1 -> MUL_START pulses once; OUT_VALID at LAUNCH+7 with OUT_P=117, OUT_ACC=117; IN_READY returns to 1.
- Back-to-back jobs (15x15, 15x15, 7x3) with ACC_W=12 -> OUT_ACC sequence 225, 450, 471. Repeat with ACC_W=8 -> 225, 194, 215 (wrap).
- Stale READY: MUL_READY held at 1 through LAUNCH and GUARD, dropped in WAIT, raised 5 cycles later with P=42 -> GUARD-cycle READY ignored; OUT_P=42 captured only after the rise.
- Core stuck (MUL_READY=0 forever), WAIT_MAX=15 -> after 15 WAIT cycles OUT_VALID=1, OUT_P=0, OUT_ACC unchanged, TIMEOUT=1. TIMEOUT stays 1 after the next good job and clears on ACC_CLR.
- Backpressure: OUT_READY=0 for 10 cycles in HOLD while IN_VALID=1 and the IN_* values change -> OUT_P/OUT_ACC stable, IN_READY=0, MUL_A/MUL_B unchanged; new job accepted the cycle after OUT_READY=1.
- RN low during WAIT, then ACC_CLR coincident with a capture of P=20 over a prior OUT_ACC=300:
  - RN low during WAIT -> immediate IDLE, all outputs 0, IN_READY=1.
  - ACC_CLR coincident with the capture -> OUT_ACC=20.
